painterengine_gpu_dma_reader: RTL and testbench
===============================================

// Module: painterengine_gpu_dma_reader
// PURPOSE
//  AXI4 full read master: fetches a 32-bit-word buffer from memory in INCR bursts and streams it to one of 4 GPU client channels.
//  Companion of the GPU DMA writer; it sits between the AXI HP port and the pixel/texture fetch units.
//  A one-hot router selects the channel; address/length are taken per channel; done/error are sticky until reset.
// PARAMETERS
//  PARAM_DATA_ALIGN  32     data beat width in bits; only 32 is supported; any other value triggers a $error at elaboration
//  PARAM_TIMEOUT     65535  watchdog limit in cycles (used only when the timeout feature is compiled in)
// PORTS
//  i_wire_clock          in   1      sole clock; all logic on its rising edge
//  i_wire_reset          in   1      synchronous, active-high reset
//  i_wire_router         in   4      one-hot channel select, sampled in ROUTING
//  i_wire_address        in   128    per-channel byte start address, ch n = [n*32+:32]
//  i_wire_length         in   128    per-channel length in 32-bit words
//  o_wire_data           out  128    per-channel read data, ch n = [n*32+:32]
//  o_wire_data_valid     out  4      beat valid for channel n
//  i_wire_data_next      in   4      client n accepts the beat (ready)
//  o_wire_done           out  1      transfer complete (sticky)
//  o_wire_error          out  1      error state (sticky)
//  o_wire_error_type     out  3      0 ok, 1 router, 2 address, 3 response, 4 timeout
//  o_wire_M_AXI_AR*      out  -      ARID=0, ARADDR[31:0], ARLEN[7:0], ARSIZE=3'b010, ARBURST=2'b01, ARLOCK=0, ARCACHE=4'b0010, ARPROT=0, ARQOS=0, ARVALID
//  i_wire_M_AXI_ARREADY  in   1      AR handshake
//  i_wire_M_AXI_R*       in   -      RID[0:0], RDATA[31:0], RRESP[1:0], RLAST, RVALID
//  o_wire_M_AXI_RREADY   out  1      R handshake
// BEHAVIOUR
//  Reset: state ROUTING; ARVALID, ARADDR, ARLEN, RREADY, all data_valid, done, error, and error_type are 0; offset and counters are 0.
//  FSM: ROUTING->PARAM_CHECK->CALC->ADDR->DATA->(CALC|DONE); any state may go ->ERROR.
//  ROUTING: router==0 stays idle; a one-hot value latches the index, address, and length; any other value goes to ERROR with type 1.
//  PARAM_CHECK: address[1:0]!=0 or length==0 goes to ERROR with type 2; otherwise offset=0 and the FSM moves to CALC.
//  CALC: rem=length-offset; cap=256-((address[9:2]+offset[7:0]) mod 256) (9-bit); burstlen=min(cap,rem).
//   In the same edge CALC sets ARADDR=address+offset*4, ARLEN=burstlen-1, ARVALID=1.
//   Bursts never cross a 1 KiB boundary.
//  Latency: ARVALID rises on the 3rd edge after a valid router is sampled in ROUTING.
//  ADDR: ARVALID and ARADDR are held stable until ARREADY; on ARVALID&&ARREADY, ARVALID=0, beat count=0, and the FSM moves to DATA.
//  DATA (combinational pass-through, zero latency):
//   o_wire_data[idx]=RDATA;
//   data_valid[idx]=RVALID&&state==DATA, and all other channels are 0;
//   RREADY=i_wire_data_next[idx]&&state==DATA.
//  A beat is RVALID&&RREADY; each beat increments the count.
//  RRESP>=2 on any beat goes to ERROR with type 3 (the beat is still handed to the client).
//  RLAST on beat k<burstlen, or RLAST missing on beat burstlen, goes to ERROR with type 3.
//  Last beat: offset+=burstlen; if offset>=length go to DONE, else go to CALC. At most one burst is outstanding at a time.
//  Backpressure: the client holding next=0 stalls R indefinitely; with the timeout feature compiled in, the stall is bounded by the watchdog.
//  DONE/ERROR: absorbing states; the router is ignored there and only i_wire_reset exits.
//  Reset mid-burst: ARVALID and RREADY are 0 at the first edge with reset high, and state returns to ROUTING.
//   The AXI slave must be reset with the block; beats still in flight are not tracked.
//  Width rules: offset and length are 32-bit unsigned; cap is a 9-bit value in 1..256; burstlen is 9 bits.
// CONFIGURATION
//  PAINTERENGINE_GPU_DMA_READER_TIMEOUT_EN defined:
//   a 16-bit counter counts consecutive cycles in ADDR or DATA without a handshake and clears on any AR or R handshake.
//   Reaching PARAM_TIMEOUT goes to ERROR, with type 3 in ADDR and type 4 in DATA.
//  Macro undefined: no counter is built, the block waits forever, and error type 4 is never produced.
// STRUCTURE
//  Shared header painterengine_gpu_dma_defs.vh holds:
//   FSM state codes;
//   error codes 0..4;
//   AXI constants ARSIZE/ARBURST/ARCACHE.
//  The writer and this reader both include it.
//  Sub-module painterengine_gpu_dma_burst_calc: combinational; inputs address, length, offset; output burstlen.
//   The same function exists on the write side and is intended to be shared.
// TESTING
//  router=4'b0010, addr=0x1000, len=4, ARREADY=1, R zero-wait -> ARADDR=0x1000 ARLEN=3; ch1 gets 4 beats; done=1; valid[0,2,3]=0.
//  addr=0x13F8 len=6 -> 1st burst ARADDR=0x13F8 ARLEN=1; 2nd burst ARADDR=0x1400 ARLEN=3; done after 6 beats.
//  len=300 addr=0x2000 -> bursts ARLEN=255 then ARLEN=43; ARADDR=0x2400 on the 2nd burst.
//  router=4'b0110 -> error=1 type=1, ARVALID never rises; addr=0x1002 -> error type=2.
//  RRESP=2'b10 on beat 2 -> error type=3 and RREADY=0 afterwards; RLAST early on beat 1 of 4 -> error type=3.
//  Timeout macro on, client next=0 for 65535 cycles in DATA -> error type=4; reset mid-DATA -> ROUTING, all outputs 0 next edge.

Source files
------------

// File: rtl/painterengine_gpu_dma_reader_pkg.sv
// Shared definitions for the GPU DMA reader: FSM state codes, error codes,
// fixed AXI read-address attributes and small router helpers.
package painterengine_gpu_dma_reader_pkg;

  typedef enum logic [2:0] {
    ST_ROUTING     = 3'd0,
    ST_PARAM_CHECK = 3'd1,
    ST_CALC        = 3'd2,
    ST_ADDR        = 3'd3,
    ST_DATA        = 3'd4,
    ST_DONE        = 3'd5,
    ST_ERROR       = 3'd6
  } state_e;

  localparam logic [2:0] ERR_OK       = 3'd0;
  localparam logic [2:0] ERR_ROUTER   = 3'd1;
  localparam logic [2:0] ERR_ADDRESS  = 3'd2;
  localparam logic [2:0] ERR_RESPONSE = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

  localparam logic [2:0] AXI_ARSIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_ARBURST_INCR = 2'b01;
  localparam logic [3:0] AXI_ARCACHE_NB   = 4'b0010;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] onehot_to_index(input logic [3:0] v);
    case (v)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/painterengine_gpu_dma_burst_calc.sv
// Burst length calculator shared with the DMA writer: the next INCR burst is
// the smaller of the remaining words and the words left before the next
// 1 KiB boundary (256 words of 32 bits).
module painterengine_gpu_dma_burst_calc (
  input  logic [31:0] address_i,
  input  logic [31:0] length_i,
  input  logic [31:0] offset_i,
  output logic [8:0]  burstlen_o
);

  logic [31:0] rem;
  logic [7:0]  word_in_kb;
  logic [8:0]  cap;
  logic        unused_ok;

  assign unused_ok = ^{address_i[31:10], address_i[1:0], offset_i[31:8]};

  // Remaining words versus room left in the current 1 KiB window
  always_comb begin
    rem        = length_i - offset_i;
    word_in_kb = address_i[9:2] + offset_i[7:0];
    cap        = 9'd256 - {1'b0, word_in_kb};
    burstlen_o = (rem < {23'd0, cap}) ? rem[8:0] : cap;
  end

endmodule

// File: rtl/painterengine_gpu_dma_reader.sv
// AXI4 read master streaming a word buffer to one of four GPU client channels.
// Optional watchdog: define PAINTERENGINE_GPU_DMA_READER_TIMEOUT_EN.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and ARVALID/ARADDR/ARLEN stay stable
// until accepted. The R channel is a zero-latency pass-through to the client.
module painterengine_gpu_dma_reader
  import painterengine_gpu_dma_reader_pkg::*;
#(
  parameter int PARAM_DATA_ALIGN = 32,
  parameter int PARAM_TIMEOUT    = 65535
) (
  input  logic         i_wire_clock,
  input  logic         i_wire_reset,
  input  logic [3:0]   i_wire_router,
  input  logic [127:0] i_wire_address,
  input  logic [127:0] i_wire_length,
  output logic [127:0] o_wire_data,
  output logic [3:0]   o_wire_data_valid,
  input  logic [3:0]   i_wire_data_next,
  output logic         o_wire_done,
  output logic         o_wire_error,
  output logic [2:0]   o_wire_error_type,
  output logic [2:0]   o_wire_state,
  output logic [0:0]   o_wire_M_AXI_ARID,
  output logic [31:0]  o_wire_M_AXI_ARADDR,
  output logic [7:0]   o_wire_M_AXI_ARLEN,
  output logic [2:0]   o_wire_M_AXI_ARSIZE,
  output logic [1:0]   o_wire_M_AXI_ARBURST,
  output logic         o_wire_M_AXI_ARLOCK,
  output logic [3:0]   o_wire_M_AXI_ARCACHE,
  output logic [2:0]   o_wire_M_AXI_ARPROT,
  output logic [3:0]   o_wire_M_AXI_ARQOS,
  output logic         o_wire_M_AXI_ARVALID,
  input  logic         i_wire_M_AXI_ARREADY,
  input  logic [0:0]   i_wire_M_AXI_RID,
  input  logic [31:0]  i_wire_M_AXI_RDATA,
  input  logic [1:0]   i_wire_M_AXI_RRESP,
  input  logic         i_wire_M_AXI_RLAST,
  input  logic         i_wire_M_AXI_RVALID,
  output logic         o_wire_M_AXI_RREADY
);

  if (PARAM_DATA_ALIGN != 32) begin : g_bad_align
    $error("painterengine_gpu_dma_reader: only 32-bit data beats are supported");
  end

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] addr_q, addr_d, len_q, len_d, offset_q, offset_d;
  logic [8:0]  burst_q, burst_d, beat_q, beat_d;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic        arvalid_q, arvalid_d, done_q, done_d, error_q, error_d;
  logic [2:0]  err_q, err_d;

  logic [8:0]  burstlen, burst_m1, beat_inc;
  logic [31:0] new_offset;
  logic        rready, r_beat;
  logic        unused_ok;

  assign unused_ok = ^i_wire_M_AXI_RID;

  painterengine_gpu_dma_burst_calc u_burst_calc (
    .address_i  (addr_q),
    .length_i   (len_q),
    .offset_i   (offset_q),
    .burstlen_o (burstlen)
  );

  assign rready = (state_q == ST_DATA) && i_wire_data_next[idx_q];
  assign r_beat = i_wire_M_AXI_RVALID && rready;

`ifdef PAINTERENGINE_GPU_DMA_READER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(PARAM_TIMEOUT);
  logic [15:0] wd_q, wd_d;

  // Watchdog register: consecutive ADDR/DATA cycles without a handshake
  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) wd_q <= '0;
    else              wd_q <= wd_d;
  end
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(PARAM_TIMEOUT);
`endif

  // Next-state and datapath updates for the transfer FSM
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    len_d      = len_q;
    offset_d   = offset_q;
    burst_d    = burst_q;
    beat_d     = beat_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    arvalid_d  = arvalid_q;
    done_d     = done_q;
    error_d    = error_q;
    err_d      = err_q;
    burst_m1   = burstlen - 9'd1;
    beat_inc   = beat_q + 9'd1;
    new_offset = offset_q + {23'd0, burst_q};
    case (state_q)
      ST_ROUTING: begin
        if (i_wire_router != 4'd0) begin
          if (is_onehot(i_wire_router)) begin
            idx_d   = onehot_to_index(i_wire_router);
            addr_d  = i_wire_address[{onehot_to_index(i_wire_router), 5'd0} +: 32];
            len_d   = i_wire_length[{onehot_to_index(i_wire_router), 5'd0} +: 32];
            state_d = ST_PARAM_CHECK;
          end else begin
            state_d = ST_ERROR;
            error_d = 1'b1;
            err_d   = ERR_ROUTER;
          end
        end
      end
      ST_PARAM_CHECK: begin
        if ((addr_q[1:0] != 2'd0) || (len_q == 32'd0)) begin
          state_d = ST_ERROR;
          error_d = 1'b1;
          err_d   = ERR_ADDRESS;
        end else begin
          offset_d = '0;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        araddr_d  = addr_q + {offset_q[29:0], 2'b00};
        arlen_d   = burst_m1[7:0];
        arvalid_d = 1'b1;
        burst_d   = burstlen;
        state_d   = ST_ADDR;
      end
      ST_ADDR: begin
        if (i_wire_M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          beat_d    = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_beat) begin
          beat_d = beat_inc;
          if (i_wire_M_AXI_RRESP[1] ||
              (i_wire_M_AXI_RLAST != (beat_inc == burst_q))) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
            err_d   = ERR_RESPONSE;
          end else if (beat_inc == burst_q) begin
            offset_d = new_offset;
            if (new_offset >= len_q) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_CALC;
            end
          end
        end
      end
      default: ;
    endcase
`ifdef PAINTERENGINE_GPU_DMA_READER_TIMEOUT_EN
    wd_d = '0;
    if (((state_q == ST_ADDR) && !i_wire_M_AXI_ARREADY) ||
        ((state_q == ST_DATA) && !r_beat)) begin
      wd_d = wd_q + 16'd1;
      if (wd_d == TIMEOUT_LIMIT) begin
        state_d   = ST_ERROR;
        error_d   = 1'b1;
        arvalid_d = 1'b0;
        err_d     = (state_q == ST_ADDR) ? ERR_RESPONSE : ERR_TIMEOUT;
      end
    end
`endif
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      state_q   <= ST_ROUTING;
      idx_q     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      offset_q  <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arvalid_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_q     <= ERR_OK;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      offset_q  <= offset_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arvalid_q <= arvalid_d;
      done_q    <= done_d;
      error_q   <= error_d;
      err_q     <= err_d;
    end
  end

  // Client-side pass-through of the R channel to the selected channel only
  always_comb begin
    o_wire_data       = '0;
    o_wire_data_valid = '0;
    if (state_q == ST_DATA) begin
      o_wire_data[{idx_q, 5'd0} +: 32] = i_wire_M_AXI_RDATA;
      o_wire_data_valid[idx_q]         = i_wire_M_AXI_RVALID;
    end
  end

  assign o_wire_M_AXI_RREADY  = rready;
  assign o_wire_M_AXI_ARID    = 1'b0;
  assign o_wire_M_AXI_ARADDR  = araddr_q;
  assign o_wire_M_AXI_ARLEN   = arlen_q;
  assign o_wire_M_AXI_ARSIZE  = AXI_ARSIZE_4B;
  assign o_wire_M_AXI_ARBURST = AXI_ARBURST_INCR;
  assign o_wire_M_AXI_ARLOCK  = 1'b0;
  assign o_wire_M_AXI_ARCACHE = AXI_ARCACHE_NB;
  assign o_wire_M_AXI_ARPROT  = 3'd0;
  assign o_wire_M_AXI_ARQOS   = 4'd0;
  assign o_wire_M_AXI_ARVALID = arvalid_q;
  assign o_wire_done          = done_q;
  assign o_wire_error         = error_q;
  assign o_wire_error_type    = err_q;
  assign o_wire_state         = state_q;

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// Bench for painterengine_gpu_dma_reader: random AXI slave and client
// backpressure, burst plan and data computed from addresses independently.
// The watchdog case is built only with PAINTERENGINE_GPU_DMA_READER_TIMEOUT_EN.
module tb_painterengine_gpu_dma_reader;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   router;
  logic [127:0] address_bus, length_bus;
  logic [127:0] data;
  logic [3:0]   data_valid, data_next;
  logic         done, error;
  logic [2:0]   err_type, state;
  logic [0:0]   arid, rid;
  logic [31:0]  araddr, rdata;
  logic [7:0]   arlen;
  logic [2:0]   arsize, arprot;
  logic [1:0]   arburst, rresp;
  logic         arlock, arvalid, arready, rlast, rvalid, rready;
  logic [3:0]   arcache, arqos;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] seed;

  painterengine_gpu_dma_reader dut (
    .i_wire_clock(clk), .i_wire_reset(reset), .i_wire_router(router),
    .i_wire_address(address_bus), .i_wire_length(length_bus),
    .o_wire_data(data), .o_wire_data_valid(data_valid), .i_wire_data_next(data_next),
    .o_wire_done(done), .o_wire_error(error), .o_wire_error_type(err_type),
    .o_wire_state(state),
    .o_wire_M_AXI_ARID(arid), .o_wire_M_AXI_ARADDR(araddr), .o_wire_M_AXI_ARLEN(arlen),
    .o_wire_M_AXI_ARSIZE(arsize), .o_wire_M_AXI_ARBURST(arburst), .o_wire_M_AXI_ARLOCK(arlock),
    .o_wire_M_AXI_ARCACHE(arcache), .o_wire_M_AXI_ARPROT(arprot), .o_wire_M_AXI_ARQOS(arqos),
    .o_wire_M_AXI_ARVALID(arvalid), .i_wire_M_AXI_ARREADY(arready),
    .i_wire_M_AXI_RID(rid), .i_wire_M_AXI_RDATA(rdata), .i_wire_M_AXI_RRESP(rresp),
    .i_wire_M_AXI_RLAST(rlast), .i_wire_M_AXI_RVALID(rvalid), .o_wire_M_AXI_RREADY(rready)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Memory content as a function of byte address
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ seed;
  endfunction

  task automatic do_reset();
    reset = 1'b1; router = '0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    rresp = '0; rid = '0; rdata = '0; data_next = '0;
    address_bus = '0; length_bus = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // mode: 0 clean, 1 RRESP error on 2nd beat, 2 early RLAST on 1st beat, 3 reset mid-DATA
  task automatic run_xfer(input logic [3:0] rt, input logic [31:0] addr, input logic [31:0] len,
                          input int mode, input logic [2:0] exp_type);
    logic [31:0] exp_addr_q[$];
    logic [7:0]  exp_len_q[$];
    logic [31:0] a, cur_addr, ar_smp;
    logic        ar_hs, r_hs, burst_on, seen_ar, finished, err_flag, bad_beat;
    int          ch, off, cap, bl, beat_i, beats_tot, gbeat;
    do_reset();
    seed = $urandom;
    exp_q.delete();
    ch = 0;
    for (int i = 0; i < 4; i++) if (rt == (4'b1 << i)) ch = i;
    off = 0;
    while (off < int'(len)) begin
      a   = addr + 32'(off * 4);
      cap = (1024 - int'(a % 1024)) / 4;
      bl  = (cap < int'(len) - off) ? cap : int'(len) - off;
      exp_addr_q.push_back(a);
      exp_len_q.push_back(8'(bl - 1));
      for (int k = 0; k < bl; k++) exp_q.push_back(word_of(a + 32'(4 * k)));
      off += bl;
    end
    for (int i = 0; i < 4; i++) begin
      address_bus[i*32 +: 32] = (i == ch) ? addr : $urandom;
      length_bus[i*32 +: 32]  = (i == ch) ? len  : $urandom;
    end
    router = rt;
    ar_hs = 0; r_hs = 0; burst_on = 0; seen_ar = 0; finished = 0; err_flag = 0;
    beat_i = 0; beats_tot = 0; gbeat = 0; cur_addr = '0; ar_smp = '0;
    for (int cyc = 1; cyc <= 6000 && !finished; cyc++) begin
      @(posedge clk); #1;
      router = '0;
      if (ar_hs) begin burst_on = 1; cur_addr = ar_smp; beats_tot = int'(exp_len_q.size() >= 0) * 0 + beats_tot; beat_i = 0; end
      if (r_hs) begin beat_i++; gbeat++; if (beat_i == beats_tot) burst_on = 0; end
      if (mode == 3 && gbeat == 2) begin
        reset = 1'b1; rvalid = 1'b1; arready = 1'b1; data_next = 4'hF;
        @(posedge clk); @(negedge clk);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_valid", data_valid, 0);
        check("rst_done_err", {done, error, err_type}, 0);
        check("rst_state", state, 0);
        reset = 1'b0; rvalid = 1'b0;
        finished = 1;
      end else begin
        arready   = 1'($urandom_range(0, 1));
        rvalid    = burst_on && ($urandom_range(0, 3) != 0);
        rdata     = burst_on ? word_of(cur_addr + 32'(4 * beat_i)) : $urandom;
        rlast     = burst_on && (beat_i == beats_tot - 1);
        rresp     = 2'b00;
        bad_beat  = 0;
        if (mode == 1 && gbeat == 1) begin rresp = 2'b10; bad_beat = 1; end
        if (mode == 2 && gbeat == 0) begin rlast = 1'b1; bad_beat = 1; end
        data_next = 4'($urandom_range(0, 15));
        @(negedge clk);
        if (arvalid && !seen_ar) begin
          seen_ar = 1;
          if (mode == 0) check("ar_latency", cyc, 3);
        end
        ar_hs = arvalid && arready;
        if (ar_hs) begin
          ar_smp = araddr;
          beats_tot = int'(arlen) + 1;
          if (exp_addr_q.size() == 0) check("ar_extra", 1, 0);
          else begin
            check("araddr", araddr, exp_addr_q.pop_front());
            check("arlen", arlen, exp_len_q.pop_front());
            check("ar_attr", {arid, arsize, arburst, arlock, arcache, arprot, arqos},
                  {1'b0, 3'b010, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000});
          end
        end
        if (burst_on) check("rready", rready, err_flag ? 1'b0 : data_next[ch]);
        r_hs = rvalid && rready;
        if (r_hs) begin
          check("valid_onehot", data_valid, 4'b1 << ch);
          if (exp_q.size() == 0) check("beat_extra", 1, 0);
          else check("data", data[ch*32 +: 32], exp_q.pop_front());
          if (bad_beat) err_flag = 1;
        end
        if (done || error) finished = 1;
      end
    end
    if (!finished) check("cycle_budget", 0, 1);
    if (mode != 3) begin
      check("done", done, exp_type == 0);
      check("error", error, exp_type != 0);
      check("error_type", err_type, exp_type);
      if (exp_type == 0) begin
        check("bursts_left", exp_addr_q.size(), 0);
        check("beats_left", exp_q.size(), 0);
      end
      if (exp_type == 1 || exp_type == 2) check("no_arvalid", seen_ar, 0);
      if (exp_type == 3) begin
        rvalid = 1'b1; data_next = 4'hF;
        repeat (2) begin
          @(negedge clk);
          check("err_rready", rready, 0);
          check("err_valid", data_valid, 0);
        end
        rvalid = 1'b0;
      end
    end
  endtask

`ifdef PAINTERENGINE_GPU_DMA_READER_TIMEOUT_EN
  task automatic run_timeout();
    int cyc;
    do_reset();
    address_bus[31:0] = 32'h100; length_bus[31:0] = 32'd4;
    router = 4'b0001; arready = 1'b1; data_next = 4'h0;
    cyc = 0;
    while (!error && cyc < 70000) begin
      @(posedge clk); #1 router = '0; rvalid = (state == 3'd4);
      cyc++;
    end
    @(negedge clk);
    check("wd_error", error, 1);
    check("wd_type", err_type, 4);
    check("wd_not_early", cyc > 65000, 1);
  endtask
`endif

  // Stimulus sequence and final report
  initial begin
    int ch;
    logic [31:0] addr, len;
    do_reset();
    @(negedge clk);
    check("reset_arvalid", arvalid, 0);
    check("reset_araddr", araddr, 0);
    check("reset_arlen", arlen, 0);
    check("reset_rready", rready, 0);
    check("reset_valid", data_valid, 0);
    check("reset_flags", {done, error, err_type}, 0);
    check("reset_state", state, 0);
    repeat (5) @(negedge clk);
    check("idle_arvalid", arvalid, 0);
    check("idle_state", state, 0);

    run_xfer(4'b0010, 32'h1000, 32'd4, 0, 3'd0);
    run_xfer(4'b0001, 32'h13F8, 32'd6, 0, 3'd0);
    run_xfer(4'b1000, 32'h2000, 32'd300, 0, 3'd0);
    run_xfer(4'b0110, 32'h1000, 32'd4, 0, 3'd1);
    run_xfer(4'b0100, 32'h1002, 32'd4, 0, 3'd2);
    run_xfer(4'b0001, 32'h1000, 32'd0, 0, 3'd2);
    run_xfer(4'b0100, 32'h3000, 32'd4, 1, 3'd3);
    run_xfer(4'b1000, 32'h3000, 32'd4, 2, 3'd3);
    run_xfer(4'b0010, 32'h4000, 32'd6, 3, 3'd0);
    for (int t = 0; t < 6; t++) begin
      ch   = $urandom_range(0, 3);
      addr = 32'h1000 * $urandom_range(1, 8) + 32'(4 * $urandom_range(0, 255));
      len  = $urandom_range(1, 300);
      run_xfer(4'b1 << ch, addr, len, 0, 3'd0);
    end
`ifdef PAINTERENGINE_GPU_DMA_READER_TIMEOUT_EN
    run_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
